// File: rtl/vga_pkg.sv
// Shared constants, derived totals and types for the VGA raster engine.
package vga_pkg;

    localparam int DEF_H_ACTIVE   = 640;
    localparam int DEF_H_FP       = 16;
    localparam int DEF_H_SYNC     = 96;
    localparam int DEF_H_BP       = 48;
    localparam int DEF_V_ACTIVE   = 480;
    localparam int DEF_V_FP       = 10;
    localparam int DEF_V_SYNC     = 2;
    localparam int DEF_V_BP       = 33;
    localparam int DEF_SCALE_LOG2 = 0;
    localparam int DEF_ADDR_W     = 19;
    localparam int DEF_RD_LAT     = 2;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    typedef logic [0:0] bank_state_t;
    localparam bank_state_t ST_IDLE    = 1'b0;
    localparam bank_state_t ST_PENDING = 1'b1;

    // Raster control bits carried down the read-latency delay line.
    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
        logic fs;
    } ctl_t;

    localparam ctl_t CTL_RESET = '{hs: 1'b1, vs: 1'b1, act: 1'b0, fs: 1'b0};

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical raster counters with raw (undelayed) sync, active and frame-start flags.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int H_W      = 10,
    parameter int V_W      = 10
) (
    input  logic           clk,
    input  logic           rst,
    output logic [H_W-1:0] h_cnt,
    output logic [V_W-1:0] v_cnt,
    output logic           hs,
    output logic           vs,
    output logic           active,
    output logic           frame_start,
    output logic           line_end,
    output logic           frame_end
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [H_W-1:0] H_ACT    = H_W'(H_ACTIVE);
    localparam logic [V_W-1:0] V_ACT    = V_W'(V_ACTIVE);
    localparam logic [H_W-1:0] HS_BEGIN = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_W-1:0] VS_BEGIN = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);

    assign line_end    = (h_cnt == H_LAST);
    assign frame_end   = line_end && (v_cnt == V_LAST);
    assign active      = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign frame_start = (h_cnt == '0) && (v_cnt == '0);
    assign hs          = !((h_cnt >= HS_BEGIN) && (h_cnt < HS_END));
    assign vs          = !((v_cnt >= VS_BEGIN) && (v_cnt < VS_END));

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (line_end) begin
            h_cnt <= '0;
            v_cnt <= frame_end ? '0 : v_cnt + V_W'(1);
        end else begin
            h_cnt <= h_cnt + H_W'(1);
        end
    end

endmodule

// File: rtl/vga_scan_engine.sv
// Parametrised VGA raster engine: frame-buffer addressing with 2^N pixel replication and
// sync/blank re-aligned to the read latency. Define VGA_DOUBLE_BUFFER_EN for bank swapping.
module vga_scan_engine
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter int SCALE_LOG2 = DEF_SCALE_LOG2,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int RD_LAT     = DEF_RD_LAT
) (
    input  logic              iVGA_CLK,
    input  logic              iRST,
    output logic [ADDR_W-1:0] oFB_ADDR,
    input  logic [23:0]       iFB_BGR,
    input  logic              iSWAP_REQ,
    output logic              oSWAP_ACK,
    output logic              oBANK,
    output logic              oFRAME_START,
    output logic              oHS,
    output logic              oVS,
    output logic              oBLANK_n,
    output logic [7:0]        b_data,
    output logic [7:0]        g_data,
    output logic [7:0]        r_data
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int H_W     = $clog2(H_TOTAL + 1);
    localparam int V_W     = $clog2(V_TOTAL + 1);
    localparam int SMASK   = (1 << SCALE_LOG2) - 1;
    localparam int PIPE_W  = RD_LAT * $bits(ctl_t);

    localparam logic [H_W-1:0]    H_SMASK = H_W'(SMASK);
    localparam logic [V_W-1:0]    V_SMASK = V_W'(SMASK);
    localparam logic [ADDR_W-1:0] COLS    = ADDR_W'(H_ACTIVE >> SCALE_LOG2);

    logic [H_W-1:0]    h_cnt;
    logic [V_W-1:0]    v_cnt;
    logic              hs_raw;
    logic              vs_raw;
    logic              act_raw;
    logic              fs_raw;
    logic              line_end;
    logic              frame_end;
    logic [ADDR_W-1:0] line_base;
    logic [ADDR_W-1:0] col_cnt;
    logic [ADDR_W-1:0] addr_hold;
    logic [ADDR_W-1:0] addr_cur;
    logic [ADDR_W-1:0] bank_base;
    ctl_t              ctl_raw;
    ctl_t [RD_LAT-1:0] ctl_pipe;
    ctl_t              ctl_out;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .H_W      (H_W),
        .V_W      (V_W)
    ) u_timing (
        .clk         (iVGA_CLK),
        .rst         (iRST),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .hs          (hs_raw),
        .vs          (vs_raw),
        .active      (act_raw),
        .frame_start (fs_raw),
        .line_end    (line_end),
        .frame_end   (frame_end)
    );

    // Address of the pixel under the raster this clock; held once the raster leaves the active area.
    assign addr_cur = bank_base + line_base + col_cnt;
    assign oFB_ADDR = act_raw ? addr_cur : addr_hold;

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            line_base <= '0;
            col_cnt   <= '0;
            addr_hold <= '0;
        end else begin
            if (frame_end) begin
                line_base <= '0;
            end else if (line_end && ((v_cnt & V_SMASK) == V_SMASK)) begin
                line_base <= line_base + COLS;
            end
            if (line_end) begin
                col_cnt <= '0;
            end else if (act_raw && ((h_cnt & H_SMASK) == H_SMASK)) begin
                col_cnt <= col_cnt + ADDR_W'(1);
            end
            if (act_raw) begin
                addr_hold <= addr_cur;
            end
        end
    end

`ifdef VGA_DOUBLE_BUFFER_EN
    localparam logic [ADDR_W-1:0] BANK_OFFSET =
        ADDR_W'((H_ACTIVE >> SCALE_LOG2) * (V_ACTIVE >> SCALE_LOG2));
    localparam logic [V_W-1:0] V_SWAP = V_W'(V_ACTIVE - 1);

    bank_state_t state;
    logic        swap_due;

    // Decided on the last clock of the final active line so the new bank and the ack
    // become visible exactly at h_cnt==0, v_cnt==V_ACTIVE.
    assign swap_due  = line_end && (v_cnt == V_SWAP);
    assign bank_base = oBANK ? BANK_OFFSET : '0;

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            state     <= ST_IDLE;
            oBANK     <= 1'b0;
            oSWAP_ACK <= 1'b0;
        end else begin
            oSWAP_ACK <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (iSWAP_REQ) state <= ST_PENDING;
                end
                ST_PENDING: begin
                    if (swap_due) begin
                        state     <= ST_IDLE;
                        oBANK     <= ~oBANK;
                        oSWAP_ACK <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
`else
    logic unused_swap_req;

    assign unused_swap_req = iSWAP_REQ;
    assign bank_base       = '0;
    assign oBANK           = 1'b0;
    assign oSWAP_ACK       = 1'b0;
`endif

    assign ctl_raw = '{hs: hs_raw, vs: vs_raw, act: act_raw, fs: fs_raw};
    assign ctl_out = ctl_pipe[RD_LAT-1];

    // Delay line: control bits wait RD_LAT clocks for the matching colour from memory.
    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            ctl_pipe <= {RD_LAT{CTL_RESET}};
        end else begin
            ctl_pipe <= PIPE_W'({ctl_pipe, ctl_raw});
        end
    end

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            oHS                      <= 1'b1;
            oVS                      <= 1'b1;
            oBLANK_n                 <= 1'b0;
            oFRAME_START             <= 1'b0;
            {b_data, g_data, r_data} <= '0;
        end else begin
            oHS          <= ctl_out.hs;
            oVS          <= ctl_out.vs;
            oBLANK_n     <= ctl_out.act;
            oFRAME_START <= ctl_out.fs;
            if (ctl_out.act) begin
                {b_data, g_data, r_data} <= iFB_BGR;
            end else begin
                {b_data, g_data, r_data} <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_scan_engine.sv
// Directed bench for vga_scan_engine: three reduced-size instances with a 2-clock memory model.
module tb_vga_scan_engine;

`ifdef VGA_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int p, ph, pv;
    int e_hs, e_vs, e_bl, e_fs, e_col;

    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    logic swap_a = 1'b0;

    // Instance A: full horizontal timing, 8-line frame, no scaling
    logic [18:0] addr_a, m1_a, m2_a;
    logic [23:0] bgr_a;
    logic        ack_a, bank_a, fs_a, hs_a, vs_a, bl_a;
    logic [7:0]  b_a, g_a, r_a;
    // Instance B: full horizontal timing, 12-line frame, 2x scaling
    logic [18:0] addr_b, m1_b, m2_b;
    logic [23:0] bgr_b;
    logic        ack_b, bank_b, fs_b, hs_b, vs_b, bl_b;
    logic [7:0]  b_b, g_b, r_b;
    // Instance C: tiny 8x4 raster
    logic [18:0] addr_c, m1_c, m2_c;
    logic [23:0] bgr_c;
    logic        ack_c, bank_c, fs_c, hs_c, vs_c, bl_c;
    logic [7:0]  b_c, g_c, r_c;

    always @(posedge clk) begin
        m1_a <= addr_a; m2_a <= m1_a;
        m1_b <= addr_b; m2_b <= m1_b;
        m1_c <= addr_c; m2_c <= m1_c;
    end
    assign bgr_a = {5'd0, m2_a};
    assign bgr_b = {5'd0, m2_b};
    assign bgr_c = {5'd0, m2_c};

    vga_scan_engine #(.V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)) dut_a (
        .iVGA_CLK(clk), .iRST(rst_a), .oFB_ADDR(addr_a), .iFB_BGR(bgr_a),
        .iSWAP_REQ(swap_a), .oSWAP_ACK(ack_a), .oBANK(bank_a), .oFRAME_START(fs_a),
        .oHS(hs_a), .oVS(vs_a), .oBLANK_n(bl_a), .b_data(b_a), .g_data(g_a), .r_data(r_a));

    vga_scan_engine #(.V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1), .SCALE_LOG2(1)) dut_b (
        .iVGA_CLK(clk), .iRST(rst_b), .oFB_ADDR(addr_b), .iFB_BGR(bgr_b),
        .iSWAP_REQ(1'b0), .oSWAP_ACK(ack_b), .oBANK(bank_b), .oFRAME_START(fs_b),
        .oHS(hs_b), .oVS(vs_b), .oBLANK_n(bl_b), .b_data(b_b), .g_data(g_b), .r_data(r_b));

    vga_scan_engine #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                      .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(0)) dut_c (
        .iVGA_CLK(clk), .iRST(rst_c), .oFB_ADDR(addr_c), .iFB_BGR(bgr_c),
        .iSWAP_REQ(1'b0), .oSWAP_ACK(ack_c), .oBANK(bank_c), .oFRAME_START(fs_c),
        .oHS(hs_c), .oVS(vs_c), .oBLANK_n(bl_c), .b_data(b_c), .g_data(g_c), .r_data(r_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic to_cyc(input int n);
        while (cyc < n) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Expected address on the 8x4 raster: row*4+col when active, otherwise the last active one.
    function automatic int c_addr(input int c);
        int h, v;
        h = c % 8;
        v = (c / 8) % 4;
        if (v < 2 && h < 4) return v * 4 + h;
        if (v < 2) return v * 4 + 3;
        return 7;
    endfunction

    task automatic chk_a_reset();
        chk("a_rst_hs", hs_a, 1);
        chk("a_rst_vs", vs_a, 1);
        chk("a_rst_blank", bl_a, 0);
        chk("a_rst_fs", fs_a, 0);
        chk("a_rst_colour", {b_a, g_a, r_a}, 0);
        chk("a_rst_addr", addr_a, 0);
        chk("a_rst_bank", bank_a, 0);
        chk("a_rst_ack", ack_a, 0);
    endtask

    initial begin
        // ---------------- Instance A ----------------
        repeat (3) @(negedge clk);
        chk_a_reset();
        rst_a = 1'b0;
        cyc = 0;
        to_cyc(2);   chk("a_fs_early", fs_a, 0); chk("a_blank_early", bl_a, 0);
        to_cyc(3);   chk("a_fs_first", fs_a, 1); chk("a_blank_first", bl_a, 1);
                     chk("a_pix00", {b_a, g_a, r_a}, 0);
        to_cyc(4);   chk("a_fs_pulse", fs_a, 0); chk("a_pix01", {b_a, g_a, r_a}, 1);
        to_cyc(643); chk("a_hblank", bl_a, 0); chk("a_hblank_col", {b_a, g_a, r_a}, 0);
        to_cyc(658); chk("a_hs_before", hs_a, 1);
        to_cyc(659); chk("a_hs_start", hs_a, 0);
        to_cyc(754); chk("a_hs_last", hs_a, 0);
        to_cyc(755); chk("a_hs_end", hs_a, 1);
        to_cyc(808); chk("a_pix_l1c5", {b_a, g_a, r_a}, 645);
        to_cyc(1000); swap_a = 1'b1;
        to_cyc(1001); swap_a = 1'b0;
        to_cyc(2000); swap_a = 1'b1;
        to_cyc(2001); swap_a = 1'b0;
        to_cyc(3199); chk("a_ack_pre", ack_a, 0); chk("a_bank_pre", bank_a, 0);
        to_cyc(3200); chk("a_ack_swap", ack_a, DB); chk("a_bank_swap", bank_a, DB);
        to_cyc(3201); chk("a_ack_once", ack_a, 0);
        to_cyc(4002); chk("a_vs_before", vs_a, 1);
        to_cyc(4003); chk("a_vs_start", vs_a, 0);
        to_cyc(5602); chk("a_vs_last", vs_a, 0);
        to_cyc(5603); chk("a_vs_end", vs_a, 1);
        to_cyc(6400); chk("a_addr_f1", addr_a, DB ? 2560 : 0);
        to_cyc(6402); chk("a_fs_f1_pre", fs_a, 0);
        to_cyc(6403); chk("a_fs_period", fs_a, 1);
                      chk("a_pix_f1", {b_a, g_a, r_a}, DB ? 2560 : 0);
        to_cyc(9599); swap_a = 1'b1;
        to_cyc(9600); swap_a = 1'b0;
                      chk("a_ack_late_req", ack_a, 0); chk("a_bank_f1", bank_a, DB);
        to_cyc(16000); chk("a_ack_f2", ack_a, DB); chk("a_bank_f2", bank_a, 0);
        to_cyc(16001); chk("a_ack_f2_once", ack_a, 0);
        to_cyc(20200); chk("a_mid_blank", bl_a, 1);
        rst_a = 1'b1;
        @(negedge clk);
        chk_a_reset();
        rst_a = 1'b0;
        cyc = 0;
        to_cyc(2); chk("a_rr_fs_early", fs_a, 0);
        to_cyc(3); chk("a_rr_fs", fs_a, 1); chk("a_rr_pix00", {b_a, g_a, r_a}, 0);

        // ---------------- Instance B ----------------
        rst_b = 1'b0;
        cyc = 0;
        chk("b_addr_0", addr_b, 0);
        to_cyc(1); chk("b_addr_1", addr_b, 0);
        to_cyc(2); chk("b_addr_2", addr_b, 1);
        to_cyc(3); chk("b_addr_3", addr_b, 1); chk("b_fs", fs_b, 1);
        to_cyc(800); chk("b_l1_start", addr_b, 0);
        to_cyc(805); chk("b_l1_c5", addr_b, 2);
        to_cyc(1600); chk("b_l2_start", addr_b, 320);
        to_cyc(1601); chk("b_l2_c1", addr_b, 320);
        to_cyc(1602); chk("b_l2_c2", addr_b, 321);
        to_cyc(1603); chk("b_l2_pix", {b_b, g_b, r_b}, 320);
        to_cyc(6239); chk("b_last_addr", addr_b, 1279);
        to_cyc(6240); chk("b_hold_addr", addr_b, 1279);
        to_cyc(9600); chk("b_wrap_addr", addr_b, 0);

        // ---------------- Instance C ----------------
        rst_c = 1'b0;
        cyc = 0;
        for (int c = 0; c < 80; c++) begin
            to_cyc(c);
            chk("c_addr", addr_c, c_addr(c));
            p = c - 3;
            if (p < 0) begin
                e_hs = 1; e_vs = 1; e_bl = 0; e_fs = 0; e_col = 0;
            end else begin
                ph = p % 8;
                pv = (p / 8) % 4;
                e_hs  = (ph == 5 || ph == 6) ? 0 : 1;
                e_vs  = (pv == 3) ? 0 : 1;
                e_bl  = (ph < 4 && pv < 2) ? 1 : 0;
                e_fs  = (p % 32 == 0) ? 1 : 0;
                e_col = e_bl ? c_addr(p) : 0;
            end
            chk("c_hs", hs_c, e_hs);
            chk("c_vs", vs_c, e_vs);
            chk("c_blank", bl_c, e_bl);
            chk("c_fs", fs_c, e_fs);
            chk("c_colour", {b_c, g_c, r_c}, e_col);
        end
        chk("c_bank", bank_c, 0);
        chk("c_ack", ack_c, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_scan_engine.md
# vga_scan_engine

Parametrised VGA raster engine that replaces the fixed 640x480 controller-plus-sync-generator pair. It generates HS/VS/BLANK from configurable timing parameters and drives a read address into an external frame buffer and palette pipeline of known latency. It supports integer pixel replication (2^N scaling), and re-aligns sync and blank to the returned colour data. It sits between the display memory (written by the processor) and the DE2-115 VGA DAC pins. Optional double buffering swaps frame-buffer banks only during vertical blanking.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in clocks
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines
- SCALE_LOG2, 0, each source pixel is repeated 2^SCALE_LOG2 times horizontally and vertically
- ADDR_W, 19, frame-buffer address width
- RD_LAT, 2, clocks from oFB_ADDR to valid iFB_BGR (memory plus palette); must be at least 1

Ports:
- iVGA_CLK, in, 1, pixel clock. Sole clock.
- iRST, in, 1, synchronous, active-high reset.
- oFB_ADDR, out, ADDR_W, frame-buffer read address.
- iFB_BGR, in, 24, palette output: {B[23:16], G[15:8], R[7:0]}.
- iSWAP_REQ, in, 1, request a bank swap at the next vertical blank.
- oSWAP_ACK, out, 1, one-clock pulse when the swap takes effect.
- oBANK, out, 1, bank currently being displayed.
- oFRAME_START, out, 1, one-clock pulse that coincides with the first active pixel on the outputs.
- oHS / oVS / oBLANK_n, out, 1 each, sync outputs (active low) and blank, aligned to the colour outputs.
- b_data / g_data / r_data, out, 8 each, pixel colour.

## Operation
- H_TOTAL is the sum of the four horizontal parameters; V_TOTAL is the sum of the four vertical ones. h_cnt counts 0..H_TOTAL-1. At wrap it returns to 0 and v_cnt increments, wrapping at V_TOTAL-1 to 0.
- Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- HS is low for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). VS is low for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- Address formula: oFB_ADDR = bank_base + (v_cnt>>S)*(H_ACTIVE>>S) + (h_cnt>>S).
  - No multiplier is used. A line_base register advances by H_ACTIVE>>S when the low S bits of v_cnt roll over at line end.
  - A column counter advances every 2^S active clocks.
  - All arithmetic is modulo 2^ADDR_W.
- oFB_ADDR holds its last value outside the active region. line_base and the column counter reset to 0 at v_cnt==0, h_cnt==0.
- bank_base is 0 for bank 0 and (H_ACTIVE>>S)*(V_ACTIVE>>S) for bank 1 (a constant).
- HS, VS, active and frame-start are delayed RD_LAT clocks by a shift register before registering onto the outputs.
- Colour outputs are forced to 0 whenever the delayed blank is low.
- FSM (bank control): IDLE -> PENDING on iSWAP_REQ=1.
  - PENDING -> IDLE at h_cnt==0, v_cnt==V_ACTIVE. At that point oBANK toggles and oSWAP_ACK pulses.
  - iSWAP_REQ while PENDING has no further effect.
  - A request arriving in the same clock as the swap point is taken at the next frame's swap point.
- Reset mid-frame: all counters, the FSM, the pipeline and the outputs return to their reset values on the next edge. The raster restarts at (0,0).

## Timing
- Reset values:
  - h_cnt, v_cnt, oFB_ADDR, oBANK: 0
  - oHS, oVS: 1
  - oBLANK_n, oSWAP_ACK, oFRAME_START: 0
  - colours: 0
  - delay pipeline: all entries inactive
- Address-to-pixel latency: the pixel for address issued at clock t appears on the colour outputs at t+RD_LAT+1, with its HS/VS/BLANK.
- First oFRAME_START after reset release occurs RD_LAT+1 clocks after h_cnt=v_cnt=0.
- Default frame length: 800 x 525 = 420000 clocks.

## Configuration
- VGA_DOUBLE_BUFFER_EN defined: bank FSM and bank_base offset are present, as described above.
- Not defined: no FSM. oBANK and oSWAP_ACK are tied to 0, iSWAP_REQ is ignored, and bank_base is 0.

## Structure
- Shared package vga_pkg holds:
  - the default timing constants
  - the derived H_TOTAL/V_TOTAL functions
  - the bank FSM state typedef (IDLE, PENDING)
- One sub-module, vga_timing_gen, holds h_cnt/v_cnt and raw HS/VS/active/frame-start generation. Address generation, the delay pipeline and the bank FSM stay in vga_scan_engine.

## Test plan
- Defaults, RD_LAT=2, memory model returning iFB_BGR=addr:
  - Frame period is 420000 clocks.
  - HS low for 96 clocks starting at h_cnt 656 (delayed by 3).
  - VS low for 2 lines.
- First active pixel after oFRAME_START has colour 0. The pixel at line 1, column 5 has colour 645. Colour is 0 whenever oBLANK_n=0.
- SCALE_LOG2=1:
  - Addresses repeat in pairs along a line, and lines repeat in pairs.
  - Line 2 starts at address 320.
  - The last active address is 76799.
- VGA_DOUBLE_BUFFER_EN defined:
  - Pulse iSWAP_REQ mid-frame. Then oSWAP_ACK fires once at v_cnt=480, h_cnt=0, and oBANK goes to 1.
  - The next frame's first address is 307200.
  - A second request in the same frame causes no extra ack.
- Assert iRST for 1 clock at v_cnt=200:
  - All outputs take their reset values on the next edge.
  - The raster restarts and the next oFRAME_START occurs RD_LAT+1 clocks after release.
- Custom 8x4 timing (H 4/1/2/1, V 2/1/1/0): counters wrap at 8 and 4, and HS is low at h_cnt 5..6 exactly.
